keypad_operand_sequencer: RTL and testbench

- Parametrised keypad entry controller for the calculator datapath. It collects N_OPERANDS BCD operands of N_DIGITS each from debounced keypad key events, enforces a post-key lockout, and issues a delayed one-cycle start to the arithmetic unit.
- Holds a result phase until cleared.
- Sits between the keypad scanner / press-edge detector and the operation unit and display.

---
 rtl/keypad_operand_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_keypad_operand_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_operand_sequencer.sv
// keypad_operand_sequencer
// ------------------------
// Collects N_OPERANDS BCD operands of N_DIGITS digits each from debounced
// keypad events. After every accepted key, further keys are ignored for
// LOCK_CYCLES cycles. When the last operand is entered, the block waits
// START_DELAY cycles and then issues a one-cycle op_start to the arithmetic
// unit. It holds the result phase until '*' is pressed.
//
// Optional build macro: BACKSPACE_EN. When it is defined, key 4'hC in ENTRY
// removes the least significant digit of the current operand.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   key_valid    one-cycle pulse that qualifies key_code
//   key_code     0-9 digit, 4'hD '*' clear, 4'hE '#' enter
//   op_done      result ready from the operation unit (used only in EXEC)
//   operands     packed BCD; operand k at [k*N_DIGITS*4 +: N_DIGITS*4],
//                digit 0 = LSD, 4'hF = blank
//   entry_idx    operand currently being entered
//   phase        0 ENTRY, 1 SETTLE, 2 EXEC, 3 RESULT
//   locked       post-key lockout active
//   op_start     one-cycle start pulse
//   result_show  high while in RESULT
module keypad_operand_sequencer #(
    parameter int N_OPERANDS  = 2,
    parameter int N_DIGITS    = 2,
    parameter int LOCK_CYCLES = 17_550_000,
    parameter int START_DELAY = 540_000,
    localparam int IDX_W      = (N_OPERANDS > 1) ? $clog2(N_OPERANDS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    input  logic [3:0]                       key_code,
    input  logic                             op_done,
    output logic [N_OPERANDS*N_DIGITS*4-1:0] operands,
    output logic [IDX_W-1:0]                 entry_idx,
    output logic [2:0]                       phase,
    output logic                             locked,
    output logic                             op_start,
    output logic                             result_show
);

    localparam int OP_W   = N_DIGITS * 4;
    localparam int ALL_W  = N_OPERANDS * OP_W;
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int DLY_W  = $clog2(START_DELAY + 1);

    localparam logic [3:0] KEY_CLEAR = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;
`ifdef BACKSPACE_EN
    localparam logic [3:0] KEY_BKSP  = 4'hC;
`endif

    typedef enum logic [2:0] {
        PH_ENTRY  = 3'd0,
        PH_SETTLE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_RESULT = 3'd3
    } phase_t;

    logic [ALL_W-1:0]  operands_q, operands_d;
    logic [IDX_W-1:0]  entry_idx_q, entry_idx_d;
    phase_t            phase_q, phase_d;
    logic              locked_q, locked_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
    logic              op_start_q, op_start_d;
    logic              result_show_q, result_show_d;

    logic [OP_W-1:0]   cur_op;
    logic [OP_W-1:0]   new_op;
    logic              cur_blank;
    logic              key_ok;
    logic              accept;
    logic              write_op;
    logic              clear_all;

    always_comb begin
        operands_d    = operands_q;
        entry_idx_d   = entry_idx_q;
        phase_d       = phase_q;
        locked_d      = locked_q;
        lock_cnt_d    = lock_cnt_q;
        dly_cnt_d     = dly_cnt_q;
        op_start_d    = 1'b0;
        result_show_d = result_show_q;
        new_op        = '1;
        accept        = 1'b0;
        write_op      = 1'b0;
        clear_all     = 1'b0;
        key_ok        = key_valid && !locked_q;

        // Constant-index mux keeps every part-select inside the vector.
        cur_op = '1;
        for (int k = 0; k < N_OPERANDS; k++) begin
            if (int'(entry_idx_q) == k) begin
                cur_op = operands_q[k*OP_W +: OP_W];
            end
        end
        cur_blank = &cur_op;

        // Lockout countdown: the counter is loaded with LOCK_CYCLES-1 on the
        // accepting edge, so locked stays high for exactly LOCK_CYCLES cycles.
        if (locked_q) begin
            if (lock_cnt_q == '0) begin
                locked_d = 1'b0;
            end else begin
                lock_cnt_d = lock_cnt_q - 1'b1;
            end
        end

        case (phase_q)
            PH_ENTRY: begin
                if (key_ok) begin
                    if (key_code <= 4'd9) begin
                        accept      = 1'b1;
                        write_op    = 1'b1;
                        new_op      = cur_op << 4;
                        new_op[3:0] = key_code;
                    end else if (key_code == KEY_ENTER && !cur_blank) begin
                        accept = 1'b1;
                        if (int'(entry_idx_q) < N_OPERANDS - 1) begin
                            entry_idx_d = entry_idx_q + 1'b1;
                        end else begin
                            phase_d   = PH_SETTLE;
                            dly_cnt_d = '0;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        accept    = 1'b1;
                        clear_all = 1'b1;
`ifdef BACKSPACE_EN
                    end else if (key_code == KEY_BKSP && !cur_blank) begin
                        accept                 = 1'b1;
                        write_op               = 1'b1;
                        new_op                 = cur_op >> 4;
                        new_op[OP_W-1 -: 4]    = 4'hF;
`endif
                    end
                end
            end
            PH_SETTLE: begin
                // An abort on the final delay cycle takes priority over op_start.
                if (key_ok && key_code == KEY_CLEAR) begin
                    accept    = 1'b1;
                    clear_all = 1'b1;
                end else if (dly_cnt_q == DLY_W'(START_DELAY - 1)) begin
                    op_start_d = 1'b1;
                    phase_d    = PH_EXEC;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            PH_EXEC: begin
                if (op_done) begin
                    phase_d       = PH_RESULT;
                    result_show_d = 1'b1;
                end
            end
            PH_RESULT: begin
                if (key_ok && key_code == KEY_CLEAR) begin
                    accept    = 1'b1;
                    clear_all = 1'b1;
                end
            end
            default: begin
                phase_d = PH_ENTRY;
            end
        endcase

        if (write_op) begin
            for (int k = 0; k < N_OPERANDS; k++) begin
                if (int'(entry_idx_q) == k) begin
                    operands_d[k*OP_W +: OP_W] = new_op;
                end
            end
        end

        if (clear_all) begin
            operands_d    = '1;
            entry_idx_d   = '0;
            phase_d       = PH_ENTRY;
            dly_cnt_d     = '0;
            result_show_d = 1'b0;
        end

        if (accept) begin
            locked_d   = 1'b1;
            lock_cnt_d = LOCK_W'(LOCK_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operands_q    <= '1;
            entry_idx_q   <= '0;
            phase_q       <= PH_ENTRY;
            locked_q      <= 1'b0;
            lock_cnt_q    <= '0;
            dly_cnt_q     <= '0;
            op_start_q    <= 1'b0;
            result_show_q <= 1'b0;
        end else begin
            operands_q    <= operands_d;
            entry_idx_q   <= entry_idx_d;
            phase_q       <= phase_d;
            locked_q      <= locked_d;
            lock_cnt_q    <= lock_cnt_d;
            dly_cnt_q     <= dly_cnt_d;
            op_start_q    <= op_start_d;
            result_show_q <= result_show_d;
        end
    end

    assign operands    = operands_q;
    assign entry_idx   = entry_idx_q;
    assign phase       = phase_q;
    assign locked      = locked_q;
    assign op_start    = op_start_q;
    assign result_show = result_show_q;

endmodule

// File: tb/tb_keypad_operand_sequencer.sv
// Directed bench for keypad_operand_sequencer (3 operands x 3 digits,
// 4-cycle lockout, 3-cycle start delay). A second instance with a 1-cycle
// lockout reaches the final SETTLE cycle unlocked, which makes the
// abort-versus-op_start collision observable.
module tb_keypad_operand_sequencer;

    localparam logic [35:0] ALL_BLANK = '1;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        op_done;
    logic [35:0] operands;
    logic [1:0]  entry_idx;
    logic [2:0]  phase;
    logic        locked;
    logic        op_start;
    logic        result_show;

    logic        key_valid2;
    logic [3:0]  key_code2;
    logic [11:0] operands2;
    logic [0:0]  entry_idx2;
    logic [2:0]  phase2;
    logic        locked2;
    logic        op_start2;
    logic        result_show2;

    int errors = 0;
    int checks = 0;

    keypad_operand_sequencer #(
        .N_OPERANDS (3),
        .N_DIGITS   (3),
        .LOCK_CYCLES(4),
        .START_DELAY(3)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .op_done    (op_done),
        .operands   (operands),
        .entry_idx  (entry_idx),
        .phase      (phase),
        .locked     (locked),
        .op_start   (op_start),
        .result_show(result_show)
    );

    keypad_operand_sequencer #(
        .N_OPERANDS (1),
        .N_DIGITS   (3),
        .LOCK_CYCLES(1),
        .START_DELAY(3)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid2),
        .key_code   (key_code2),
        .op_done    (1'b0),
        .operands   (operands2),
        .entry_idx  (entry_idx2),
        .phase      (phase2),
        .locked     (locked2),
        .op_start   (op_start2),
        .result_show(result_show2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [11:0] opnd(input int k);
        return operands[k*12 +: 12];
    endfunction

    // Key held for one cycle; returns 1ns after the sampling edge.
    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic press2(input logic [3:0] c);
        key_valid2 = 1'b1;
        key_code2  = c;
        tick();
        key_valid2 = 1'b0;
        key_code2  = 4'h0;
    endtask

    task automatic wait_unlock();
        int n = 0;
        while (locked && n < 20) begin
            tick();
            n++;
        end
        chk("unlock_bound", 64'(locked), 64'd0);
    endtask

    // Called in the first cycle after an accepted key: high 4 cycles, then low.
    task automatic lock_profile(input string tag);
        chk(tag, 64'(locked), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(tag, 64'(locked), 64'd1);
        end
        tick();
        chk(tag, 64'(locked), 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        op_done    = 1'b0;
        key_valid2 = 1'b0;
        key_code2  = 4'h0;
        tick();
        tick();

        // Reset state
        chk("rst_operands", 64'(operands), 64'(ALL_BLANK));
        chk("rst_idx", 64'(entry_idx), 64'd0);
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_op_start", 64'(op_start), 64'd0);
        chk("rst_result", 64'(result_show), 64'd0);
        rst = 1'b1;
        tick();

        // op_done outside EXEC does nothing
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("done_in_entry", 64'(phase), 64'd0);

        // Keys 1,2,3,4 six cycles apart
        press(4'd1);
        chk("op0_after_1", 64'(opnd(0)), 64'hFF1);
        lock_profile("lock_k1");
        tick();
        press(4'd2);
        chk("op0_after_2", 64'(opnd(0)), 64'hF12);
        lock_profile("lock_k2");
        tick();
        press(4'd3);
        chk("op0_after_3", 64'(opnd(0)), 64'h123);
        lock_profile("lock_k3");
        tick();
        press(4'd4);
        chk("op0_wrap", 64'(opnd(0)), 64'h234);
        lock_profile("lock_k4");
        tick();

        // Key during lockout is ignored and does not extend it
        press(4'd5);
        chk("op0_after_5", 64'(opnd(0)), 64'h345);
        tick();
        press(4'd6);
        chk("key6_ignored", 64'(opnd(0)), 64'h345);
        tick();
        chk("no_extend_hi", 64'(locked), 64'd1);
        press(4'd7);              // last locked cycle
        chk("last_lock_ign", 64'(opnd(0)), 64'h345);
        chk("no_extend_lo", 64'(locked), 64'd0);
        press(4'd0);              // first unlocked cycle
        chk("first_unlock", 64'(opnd(0)), 64'h450);
        chk("first_unl_lk", 64'(locked), 64'd1);

        // Clear, '#' on blank operand, then full entry
        wait_unlock();
        press(4'hD);
        chk("clr_operands", 64'(operands), 64'(ALL_BLANK));
        wait_unlock();
        press(4'hE);
        chk("blank_enter_ix", 64'(entry_idx), 64'd0);
        chk("blank_enter_lk", 64'(locked), 64'd0);
        press(4'd7);
        wait_unlock();
        press(4'hE);
        chk("idx_1", 64'(entry_idx), 64'd1);
        wait_unlock();
        press(4'd8);
        wait_unlock();
        press(4'hE);
        chk("idx_2", 64'(entry_idx), 64'd2);
        wait_unlock();
        press(4'd9);
        wait_unlock();
        press(4'hE);
        chk("settle_phase", 64'(phase), 64'd1);
        chk("settle_start0", 64'(op_start), 64'd0);
        chk("ops_entered", 64'(operands), 64'hFF9_FF8_FF7);
        tick();
        chk("settle_start1", 64'(op_start), 64'd0);
        tick();
        chk("settle_start2", 64'(op_start), 64'd0);
        chk("settle_ph2", 64'(phase), 64'd1);
        tick();
        chk("op_start_fire", 64'(op_start), 64'd1);
        chk("exec_phase", 64'(phase), 64'd2);
        tick();
        chk("op_start_once", 64'(op_start), 64'd0);

        // EXEC ignores keys; op_done moves to RESULT
        press(4'd3);
        chk("exec_key_lk", 64'(locked), 64'd0);
        chk("exec_key_op", 64'(opnd(2)), 64'hFF9);
        press(4'hD);
        chk("exec_clr_ign", 64'(phase), 64'd2);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        chk("result_phase", 64'(phase), 64'd3);
        chk("result_show", 64'(result_show), 64'd1);
        press(4'd5);
        chk("result_hold", 64'(operands), 64'hFF9_FF8_FF7);
        chk("result_key_lk", 64'(locked), 64'd0);
        press(4'hD);
        chk("res_clr_phase", 64'(phase), 64'd0);
        chk("res_clr_ops", 64'(operands), 64'(ALL_BLANK));
        chk("res_clr_idx", 64'(entry_idx), 64'd0);
        chk("res_clr_show", 64'(result_show), 64'd0);
        chk("res_clr_lock", 64'(locked), 64'd1);

        // Abort on the final SETTLE cycle (1-cycle-lockout instance)
        press2(4'd1);
        tick();
        press2(4'hE);
        chk("d2_settle", 64'(phase2), 64'd1);
        tick();
        chk("d2_settle_e1", 64'(phase2), 64'd1);
        tick();
        press2(4'hD);
        chk("d2_abort_start", 64'(op_start2), 64'd0);
        chk("d2_abort_phase", 64'(phase2), 64'd0);
        chk("d2_abort_ops", 64'(operands2), 64'hFFF);
        chk("d2_abort_lock", 64'(locked2), 64'd1);
        tick();
        chk("d2_no_late", 64'(op_start2), 64'd0);

        // Backspace key
        wait_unlock();
        press(4'd1);
        wait_unlock();
        press(4'd2);
        wait_unlock();
        press(4'hC);
`ifdef BACKSPACE_EN
        chk("bksp_op0", 64'(opnd(0)), 64'hFF1);
        chk("bksp_lock", 64'(locked), 64'd1);
`else
        chk("bksp_op0", 64'(opnd(0)), 64'hF12);
        chk("bksp_lock", 64'(locked), 64'd0);
`endif

        // Asynchronous reset in mid-cycle
        wait_unlock();
        press(4'd4);
        #2 rst = 1'b0;
        #1;
        chk("async_ops", 64'(operands), 64'(ALL_BLANK));
        chk("async_lock", 64'(locked), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
